// File: rtl/oflow_similarity_scheduler.sv
// oflow_similarity_scheduler
//
// Purpose:
//   Sequences the similarity-metric PE for one current-frame object against
//   up to MAX_PREV previous-frame entries. For each entry it strobes a
//   feature-buffer read, pulses the PE start and waits for the PE result.
//   It then folds the score/id into a running minimum. When the scan ends it
//   reports the lowest score and its id.
//
// Ports:
//   clk          in   1         rising-edge clock
//   reset_N      in   1         synchronous, active-low reset
//   start        in   1         begin a scan (accepted only in IDLE)
//   num_prev     in   ADDR_W+1  entries to scan, clamped to MAX_PREV
//   rd_en        out  1         feature-buffer read strobe
//   rd_addr      out  ADDR_W    feature-buffer read address
//   sim_start    out  1         one-cycle start pulse to the PE
//   sim_valid    in   1         PE result valid
//   sim_score    in   SCORE_W   PE score (unsigned compare)
//   sim_id       in   ID_W      PE id
//   busy         out  1         high whenever not IDLE
//   done         out  1         one-cycle pulse, best_* final
//   best_score   out  SCORE_W   lowest score of the scan
//   best_id      out  ID_W      id paired with best_score
//   timeout_err  out  1         sticky PE-timeout flag, cleared on start
//
// Optional feature (macro OFLOW_SIM_THRESHOLD_EN):
//   match_thr    in   SCORE_W   acceptance threshold
//   no_match     out  1         best_score above threshold, empty scan or
//                               timeout. Valid with done, held until the
//                               next accepted start.
//
// Assumes MAX_PREV >= 2 so that ADDR_W is at least 1.

`ifndef SCORE_LEN
`define SCORE_LEN 32
`endif
`ifndef ID_LEN
`define ID_LEN 8
`endif

module oflow_similarity_scheduler #(
    parameter int MAX_PREV = 32,
    parameter int TIMEOUT  = 63,
    parameter int SCORE_W  = `SCORE_LEN,
    parameter int ID_W     = `ID_LEN,
    parameter int ADDR_W   = $clog2(MAX_PREV)
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start,
    input  logic [ADDR_W:0]    num_prev,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               sim_start,
    input  logic               sim_valid,
    input  logic [SCORE_W-1:0] sim_score,
    input  logic [ID_W-1:0]    sim_id,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] best_score,
    output logic [ID_W-1:0]    best_id,
    output logic               timeout_err
`ifdef OFLOW_SIM_THRESHOLD_EN
    ,
    input  logic [SCORE_W-1:0] match_thr,
    output logic               no_match
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]  MAX_N     = (ADDR_W + 1)'(MAX_PREV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        KICK,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W:0]    num_lat;
    logic [CNT_W-1:0]   wait_cnt;
    logic [ADDR_W:0]    num_clamped;
    logic               last_entry;
    logic               wait_expired;

    assign num_clamped  = (num_prev > MAX_N) ? MAX_N : num_prev;
    // Compared as idx+1 == num_lat so an empty scan never underflows.
    assign last_entry   = (({1'b0, idx} + (ADDR_W + 1)'(1)) == num_lat);
    // The last WAIT cycle is the one where the counter reads TIMEOUT-1;
    // a valid arriving on that same cycle still takes priority.
    assign wait_expired = (wait_cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        sim_start  = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        rd_addr    = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_clamped == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rd_en      = 1'b1;
                state_next = KICK;
            end
            KICK: begin
                sim_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (sim_valid) begin
                    state_next = last_entry ? DONE : FETCH;
                end else if (wait_expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state       <= IDLE;
            idx         <= '0;
            num_lat     <= '0;
            wait_cnt    <= '0;
            best_score  <= '1;
            best_id     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_lat     <= num_clamped;
                        best_score  <= '1;
                        best_id     <= '0;
                        idx         <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                KICK: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (sim_valid) begin
                        // Strict compare: ties keep the earlier entry.
                        if (sim_score < best_score) begin
                            best_score <= sim_score;
                            best_id    <= sim_id;
                        end
                        if (!last_entry) begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end else if (wait_expired) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OFLOW_SIM_THRESHOLD_EN
    logic no_match_now;
    logic no_match_hold;

    // All inputs to the verdict are final once in DONE; the held copy keeps
    // it visible after the scan returns to IDLE.
    assign no_match_now = (best_score > match_thr) || (num_lat == '0) || timeout_err;
    assign no_match     = (state == DONE) ? no_match_now : no_match_hold;

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            no_match_hold <= 1'b0;
        end else if (state == IDLE && start) begin
            no_match_hold <= 1'b0;
        end else if (state == DONE) begin
            no_match_hold <= no_match_now;
        end
    end
`endif

endmodule

// File: tb/tb_oflow_similarity_scheduler.sv
// tb_oflow_similarity_scheduler
//
// Purpose:
//   Self-checking bench for oflow_similarity_scheduler. A behavioural PE
//   answers each sim_start after a per-entry latency, which may be withheld
//   to force a timeout. A loop-based reference model predicts best score/id,
//   timeout, fetch count and scan latency. Directed cases come first,
//   followed by randomized scans.
//
// Ports: none (top-level bench). Honours OFLOW_SIM_THRESHOLD_EN.

`timescale 1ns/1ps

module tb_oflow_similarity_scheduler;

    localparam int MAX_PREV = 32;
    localparam int TIMEOUT  = 63;
    localparam int SCORE_W  = 32;
    localparam int ID_W     = 8;
    localparam int ADDR_W   = 5;
    localparam logic [SCORE_W-1:0] ALL_ONES = '1;

    logic               clk;
    logic               reset_N;
    logic               start;
    logic [ADDR_W:0]    num_prev;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               sim_start;
    logic               sim_valid;
    logic [SCORE_W-1:0] sim_score;
    logic [ID_W-1:0]    sim_id;
    logic               busy;
    logic               done;
    logic [SCORE_W-1:0] best_score;
    logic [ID_W-1:0]    best_id;
    logic               timeout_err;
`ifdef OFLOW_SIM_THRESHOLD_EN
    logic [SCORE_W-1:0] match_thr;
    logic               no_match;
`endif

    // PE model outputs and a stray-valid injector share the PE result bus.
    logic               pe_valid;
    logic [SCORE_W-1:0] pe_score;
    logic [ID_W-1:0]    pe_id;
    logic               stray_valid;
    logic [SCORE_W-1:0] stray_score;
    logic [ID_W-1:0]    stray_id;

    assign sim_valid = pe_valid | stray_valid;
    assign sim_score = stray_valid ? stray_score : pe_score;
    assign sim_id    = stray_valid ? stray_id : pe_id;

    // Per-entry PE behaviour; lat == 0 means the PE never answers.
    logic [SCORE_W-1:0] scores [MAX_PREV];
    logic [ID_W-1:0]    ids    [MAX_PREV];
    int                 lat    [MAX_PREV];

    int checks;
    int errors;
    int done_cnt;
    int kicks;
    int addr_log [$];

    int d0, k0, a0;
    logic               d_busy;
    logic               d_to;
    logic [SCORE_W-1:0] d_score;
    logic [ID_W-1:0]    d_id;
    logic               d_nm;

    oflow_similarity_scheduler #(
        .MAX_PREV (MAX_PREV),
        .TIMEOUT  (TIMEOUT),
        .SCORE_W  (SCORE_W),
        .ID_W     (ID_W)
    ) dut (
        .clk         (clk),
        .reset_N     (reset_N),
        .start       (start),
        .num_prev    (num_prev),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .sim_start   (sim_start),
        .sim_valid   (sim_valid),
        .sim_score   (sim_score),
        .sim_id      (sim_id),
        .busy        (busy),
        .done        (done),
        .best_score  (best_score),
        .best_id     (best_id),
        .timeout_err (timeout_err)
`ifdef OFLOW_SIM_THRESHOLD_EN
        ,
        .match_thr   (match_thr),
        .no_match    (no_match)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PE model and monitor. Runs on the falling edge so DUT outputs are stable.
    // A sim_start seen on one falling edge produces a valid lat cycles later,
    // so the DUT samples it after exactly lat cycles in WAIT.
    initial begin
        int cur;
        int cnt;
        bit pend;
        pe_valid = 1'b0;
        pe_score = '0;
        pe_id    = '0;
        done_cnt = 0;
        kicks    = 0;
        cur      = 0;
        cnt      = 0;
        pend     = 1'b0;
        forever begin
            @(negedge clk);
            pe_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pe_valid = 1'b1;
                    pe_score = scores[cur];
                    pe_id    = ids[cur];
                    pend     = 1'b0;
                end
            end
            if (rd_en) begin
                cur = int'(rd_addr);
                addr_log.push_back(int'(rd_addr));
            end
            if (sim_start) begin
                kicks++;
                if (lat[cur] != 0) begin
                    pend = 1'b1;
                    cnt  = lat[cur];
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the entries in order, keep the first strict minimum,
    // stop at the first entry whose PE never answers within TIMEOUT cycles.
    function automatic void model_scan(input int n,
                                       output logic [SCORE_W-1:0] e_score,
                                       output logic [ID_W-1:0] e_id,
                                       output logic e_to,
                                       output int e_fetch,
                                       output int e_cycles,
                                       output int e_eff);
        e_eff    = (n > MAX_PREV) ? MAX_PREV : n;
        e_score  = ALL_ONES;
        e_id     = '0;
        e_to     = 1'b0;
        e_fetch  = 0;
        e_cycles = 0;
        for (int i = 0; i < e_eff; i++) begin
            e_fetch++;
            if (lat[i] == 0 || lat[i] > TIMEOUT) begin
                e_to     = 1'b1;
                e_cycles += 2 + TIMEOUT;
                break;
            end
            e_cycles += 2 + lat[i];
            if (scores[i] < e_score) begin
                e_score = scores[i];
                e_id    = ids[i];
            end
        end
    endfunction

    // Launches a scan. start is held for 'hold' cycles and re-pulsed on
    // cycle 'repulse_at' with a different num_prev. Waits (bounded) for done.
    task automatic apply_stimulus(input int n, input int hold, input int repulse_at,
                                  output int cycles, output bit seen);
        @(negedge clk);
        #1;
        d0 = done_cnt;
        k0 = kicks;
        a0 = addr_log.size();
        start    = 1'b1;
        num_prev = (ADDR_W + 1)'(n);
        @(negedge clk);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < 3000) begin
            start = (cycles < hold - 1) || (cycles == repulse_at);
            if (cycles == repulse_at) num_prev = (ADDR_W + 1)'(1);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
        d_busy  = busy;
        d_score = best_score;
        d_id    = best_id;
        d_to    = timeout_err;
`ifdef OFLOW_SIM_THRESHOLD_EN
        d_nm    = no_match;
`else
        d_nm    = 1'b0;
`endif
    endtask

    task automatic check_output(input int n, input int cycles, input bit seen);
        logic [SCORE_W-1:0] e_score;
        logic [ID_W-1:0]    e_id;
        logic               e_to;
        int                 e_fetch;
        int                 e_cycles;
        int                 e_eff;
        bit                 seq_ok;
        model_scan(n, e_score, e_id, e_to, e_fetch, e_cycles, e_eff);
        check("done_seen",    64'(seen), 64'(1));
        check("latency",      64'(cycles), 64'(e_cycles));
        check("busy_at_done", 64'(d_busy), 64'(1));
        check("best_score",   64'(d_score), 64'(e_score));
        check("best_id",      64'(d_id), 64'(e_id));
        check("timeout_err",  64'(d_to), 64'(e_to));
`ifdef OFLOW_SIM_THRESHOLD_EN
        check("no_match", 64'(d_nm),
              64'((e_score > match_thr) || (e_eff == 0) || e_to));
`endif
        @(negedge clk);
        start = 1'b0;
        #1;
        check("done_width",  64'(done), 64'(0));
        check("busy_after",  64'(busy), 64'(0));
        check("done_count",  64'(done_cnt - d0), 64'(1));
        check("kicks",       64'(kicks - k0), 64'(e_fetch));
        check("fetches",     64'(addr_log.size() - a0), 64'(e_fetch));
        seq_ok = 1'b1;
        for (int j = 0; j < e_fetch && (a0 + j) < addr_log.size(); j++) begin
            if (addr_log[a0 + j] != j) seq_ok = 1'b0;
        end
        check("rd_addr_seq", 64'(seq_ok), 64'(1));
        check("best_held",   64'(best_score), 64'(e_score));
    endtask

    task automatic set_entry(input int i, input int s, input int id, input int l);
        scores[i] = SCORE_W'(s);
        ids[i]    = ID_W'(id);
        lat[i]    = l;
    endtask

    initial begin
        int cyc;
        bit seen;
        int n;
        checks      = 0;
        errors      = 0;
        reset_N     = 1'b0;
        start       = 1'b0;
        num_prev    = '0;
        stray_valid = 1'b0;
        stray_score = '0;
        stray_id    = '0;
`ifdef OFLOW_SIM_THRESHOLD_EN
        match_thr   = '0;
`endif
        for (int i = 0; i < MAX_PREV; i++) set_entry(i, 1000, 0, 1);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_done",  64'(done), 64'(0));
        check("rst_rd_en", 64'(rd_en), 64'(0));
        check("rst_start", 64'(sim_start), 64'(0));
        check("rst_addr",  64'(rd_addr), 64'(0));
        check("rst_score", 64'(best_score), 64'(ALL_ONES));
        check("rst_id",    64'(best_id), 64'(0));
        check("rst_to",    64'(timeout_err), 64'(0));
`ifdef OFLOW_SIM_THRESHOLD_EN
        check("rst_nm",    64'(no_match), 64'(0));
`endif
        reset_N = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] three entries, best in the middle");
        set_entry(0, 40, 7, 3);
        set_entry(1, 12, 8, 1);
        set_entry(2, 25, 9, 5);
`ifdef OFLOW_SIM_THRESHOLD_EN
        match_thr = SCORE_W'(10);
`endif
        apply_stimulus(3, 1, -1, cyc, seen);
        check_output(3, cyc, seen);
`ifdef OFLOW_SIM_THRESHOLD_EN
        match_thr = SCORE_W'(12);
        apply_stimulus(3, 1, -1, cyc, seen);
        check_output(3, cyc, seen);
`endif

        $display("[TB] stray sim_valid in IDLE");
        @(negedge clk);
        stray_valid = 1'b1;
        stray_score = '0;
        stray_id    = ID_W'(99);
        @(negedge clk);
        stray_valid = 1'b0;
        check("stray_score", 64'(best_score), 64'(12));
        check("stray_id",    64'(best_id), 64'(8));

        $display("[TB] tie keeps first");
        set_entry(0, 5, 1, 2);
        set_entry(1, 5, 2, 2);
        apply_stimulus(2, 1, -1, cyc, seen);
        check_output(2, cyc, seen);

        $display("[TB] empty scan, start held into DONE");
        apply_stimulus(0, 2, -1, cyc, seen);
        check_output(0, cyc, seen);

        $display("[TB] timeout on entry 1 of 4");
        set_entry(0, 30, 3, 2);
        set_entry(1, 1, 4, 0);
        set_entry(2, 2, 5, 2);
        set_entry(3, 3, 6, 2);
        apply_stimulus(4, 1, -1, cyc, seen);
        check_output(4, cyc, seen);

        $display("[TB] valid on the last WAIT cycle wins");
        set_entry(0, 9, 10, TIMEOUT);
        set_entry(1, 4, 11, 1);
        apply_stimulus(2, 1, -1, cyc, seen);
        check_output(2, cyc, seen);

        $display("[TB] valid one cycle too late");
        set_entry(0, 9, 10, TIMEOUT + 1);
        apply_stimulus(1, 1, -1, cyc, seen);
        check_output(1, cyc, seen);
        repeat (4) @(negedge clk);

        $display("[TB] start re-pulsed mid-scan");
        set_entry(0, 40, 7, 3);
        set_entry(1, 12, 8, 1);
        set_entry(2, 25, 9, 5);
        apply_stimulus(3, 1, 4, cyc, seen);
        check_output(3, cyc, seen);

        $display("[TB] num_prev above MAX_PREV clamps");
        for (int i = 0; i < MAX_PREV; i++) set_entry(i, 50, 100 + i, 1);
        set_entry(MAX_PREV - 1, 3, 200, 1);
        apply_stimulus(50, 1, -1, cyc, seen);
        check_output(50, cyc, seen);

        $display("[TB] reset mid-WAIT");
        for (int i = 0; i < 4; i++) set_entry(i, 1 + i, 20 + i, 20);
        @(negedge clk);
        #1;
        d0 = done_cnt;
        k0 = kicks;
        start    = 1'b1;
        num_prev = (ADDR_W + 1)'(4);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", 64'(busy), 64'(1));
        reset_N = 1'b0;
        @(negedge clk);
        check("rst_mid_busy",  64'(busy), 64'(0));
        check("rst_mid_done",  64'(done), 64'(0));
        check("rst_mid_score", 64'(best_score), 64'(ALL_ONES));
        reset_N = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("rst_mid_nodone", 64'(done_cnt - d0), 64'(0));
        check("rst_mid_kicks",  64'(kicks - k0), 64'(1));
        check("rst_mid_idle",   64'(busy), 64'(0));
        check("rst_mid_hold",   64'(best_score), 64'(ALL_ONES));

        $display("[TB] randomized scans");
        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(0, 40));
            for (int i = 0; i < MAX_PREV; i++) begin
                set_entry(i,
                          ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20)),
                          int'($urandom_range(0, 255)),
                          int'($urandom_range(1, 4)));
            end
            if ($urandom_range(0, 3) == 0 && n > 0) begin
                lat[$urandom_range(0, ((n > MAX_PREV) ? MAX_PREV : n) - 1)] = 0;
            end
`ifdef OFLOW_SIM_THRESHOLD_EN
            match_thr = SCORE_W'($urandom_range(0, 20));
`endif
            apply_stimulus(n, 1, -1, cyc, seen);
            check_output(n, cyc, seen);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
